// File: rtl/daq_link_sender.sv
// daq_link_sender: buffers DAQ words in a FIFO, streams them to the link, checks event framing
module daq_link_sender #(
  parameter int DEPTH     = 16,
  parameter int MAX_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] daq_data,
  input  logic        daq_header,
  input  logic        daq_trailer,
  input  logic        daq_valid,
  output logic        daq_ready,
  output logic [63:0] link_data,
  output logic        link_header,
  output logic        link_trailer,
  output logic        link_wen,
  input  logic        link_ready,
  input  logic        link_almost_full,
  output logic [23:0] event_count,
  output logic [15:0] last_word_count,
  output logic        seq_error,
  output logic        len_error,
  output logic        trig_error
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, BODY} state_t;
  logic [65:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic rdy_en, push, pop;
  state_t state, state_nxt;
  logic [15:0] wcnt, wcnt_nxt;
  logic [16:0] wcnt_inc;
  logic [1:0] hdr_trig;
  logic seq_set, len_set, trig_set, evt_done;
  assign daq_ready = rdy_en && count != (AW+1)'(DEPTH);
  assign push = daq_valid && daq_ready;
  assign pop = count != '0 && link_ready && !link_almost_full;
  assign wcnt_inc = {1'b0, wcnt} + 17'd1;
  // FIFO storage, {header, trailer, data} per entry; contents need no reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {daq_header, daq_trailer, daq_data};
  // FIFO pointers/occupancy and the registered link output stage
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rdy_en <= 1'b0;
      link_wen <= 1'b0;
      {link_header, link_trailer, link_data} <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      link_wen <= pop;
      if (pop) {link_header, link_trailer, link_data} <= mem[rd_ptr];
    end
  // Framer next state and error/event events, evaluated on accepted words only
  always_comb begin
    state_nxt = state;
    wcnt_nxt = wcnt;
    seq_set = 1'b0;
    len_set = 1'b0;
    trig_set = 1'b0;
    evt_done = 1'b0;
    if (push) begin
      if (daq_header && daq_trailer) begin
        state_nxt = IDLE;
        seq_set = 1'b1;
      end else if (daq_header) begin
        state_nxt = BODY;
        wcnt_nxt = 16'd1;
        seq_set = state == BODY;
      end else if (state == IDLE) begin
        seq_set = 1'b1;
      end else begin
        len_set = wcnt_inc > 17'(MAX_WORDS);
        wcnt_nxt = wcnt_inc[16] ? 16'hFFFF : wcnt_inc[15:0];
        trig_set = daq_trailer && daq_data[25:24] != hdr_trig;
        evt_done = daq_trailer;
        state_nxt = daq_trailer ? IDLE : BODY;
      end
    end
  end
  // Framer state, header trigger latch, statistics and sticky error flags
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      wcnt <= '0;
      hdr_trig <= '0;
      event_count <= '0;
      last_word_count <= '0;
      seq_error <= 1'b0;
      len_error <= 1'b0;
      trig_error <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt <= wcnt_nxt;
      if (push && daq_header && !daq_trailer) hdr_trig <= daq_data[33:32];
      if (evt_done) event_count <= event_count + 1'b1;
      if (evt_done) last_word_count <= wcnt_nxt;
      seq_error <= seq_error | seq_set;
      len_error <= len_error | len_set;
      trig_error <= trig_error | trig_set;
    end
endmodule
